// File: rtl/aes_ks_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-256 key schedule.
// The InvMixColumns helpers are only pulled in when AES_KS_EQINV_MIXCOL_EN is defined.
package aes_ks_pkg;
  localparam int NK     = 8;
  localparam int NR     = 14;
  localparam int NWORDS = 60;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;

  localparam logic [7:1][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier is restricted to 4 bits: InvMixColumns only needs 9, 11, 13, 14.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{m[0]}} & b) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
            gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
            gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
            gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction
endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel forward AES S-box lookups, one per byte lane.
module aes_sbox_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] b;
    assign b = din[8*g +: 8];
    assign dout[8*g +: 8] = SBOX[2047 - 8*int'(b) -: 8];
  end
endmodule

// File: rtl/aes256_key_schedule_seq.sv
// AES-256 key expansion, one word per cycle (52 busy cycles per key) into a 60-word store with a random-access round-key read port.
// AES_KS_EQINV_MIXCOL_EN: rounds 1..13 are read back through InvMixColumns; key_ready stays low while expanding.
module aes256_key_schedule_seq
  import aes_ks_pkg::*;
#(
  parameter bit OUT_REG = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         rk_valid,
  output logic         busy
);
  ks_state_t    state, state_nxt;
  logic [5:0]   widx;
  logic [31:0]  store [NWORDS];
  logic         accept;
  logic [31:0]  w_prev, w_back, sub_in, sub_out, t_word;
  logic [7:0]   rcon_byte;
  logic [5:0]   rbase;
  logic [127:0] rd_raw, rd_word;

  assign key_ready = (state != EXPAND);
  assign accept    = key_valid && key_ready;
  assign busy      = (state == EXPAND);
  assign rk_valid  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = EXPAND;
      EXPAND:     if (widx == 6'(NWORDS - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Single word engine: w[i] = w[i-8] ^ t, with t selected by i mod 8.
  assign w_prev    = store[widx - 6'd1];
  assign w_back    = store[widx - 6'(NK)];
  assign sub_in    = (widx[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;
  assign rcon_byte = (widx[5:3] == 3'd0) ? 8'h00 : RCON[widx[5:3]];

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    case (widx[2:0])
      3'd0:    t_word = sub_out ^ {rcon_byte, 24'h0};
      3'd4:    t_word = sub_out;
      default: t_word = w_prev;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx <= '0;
      for (int k = 0; k < NWORDS; k++) store[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NK; k++) store[k] <= key[255 - 32*k -: 32];
      widx <= 6'(NK);
    end else if (state == EXPAND) begin
      store[widx] <= w_back ^ t_word;
      widx        <= widx + 6'd1;
    end
  end

  assign rbase = {rk_idx, 2'b00};

  always_comb begin
    rd_raw = '0;
    if (rk_idx <= 4'(NR))
      rd_raw = {store[rbase], store[rbase + 6'd1], store[rbase + 6'd2], store[rbase + 6'd3]};
  end

`ifdef AES_KS_EQINV_MIXCOL_EN
  assign rd_word = (rk_idx != 4'd0 && rk_idx < 4'(NR)) ? inv_mix_columns(rd_raw) : rd_raw;
`else
  assign rd_word = rd_raw;
`endif

  if (OUT_REG) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rk_data <= '0;
      else        rk_data <= rd_word;
    end
  end else begin : g_comb
    assign rk_data = rd_word;
  end
endmodule

// File: tb/tb_aes256_key_schedule_seq.sv
// Scoreboard bench: combinational-read and registered-read instances share stimulus and are checked against an algebraic AES model.
module tb_aes256_key_schedule_seq;
  localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] A3_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic         clk = 1'b0;
  logic         rst_n, key_valid;
  logic [255:0] key;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data0, rk_data1;
  logic         key_ready0, key_ready1, rk_valid0, rk_valid1, busy0, busy1;
  logic         rd_vld;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0]  mw [60];
  logic [127:0] q0 [$];
  logic [127:0] q1 [$];

  always #5 clk = ~clk;

  aes256_key_schedule_seq #(.OUT_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready0), .key(key),
    .rk_idx(rk_idx), .rk_data(rk_data0), .rk_valid(rk_valid0), .busy(busy0));

  aes256_key_schedule_seq #(.OUT_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready1), .key(key),
    .rk_idx(rk_idx), .rk_data(rk_data1), .rk_valid(rk_valid1), .busy(busy1));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: field arithmetic and the textbook expansion rules.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int k = 0; k < 254; k++) inv = gf_mul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  function automatic logic [31:0] imc_col_ref(input logic [31:0] c);
    logic [7:0] coef [4] = '{8'd14, 8'd11, 8'd13, 8'd9};
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        r[31-8*j -: 8] = r[31-8*j -: 8] ^ gf_mul(coef[(k - j + 4) % 4], c[31-8*k -: 8]);
    return r;
  endfunction

  task automatic model_expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) mw[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = mw[i-1];
      if (i % 8 == 0)      t = sub_word_ref({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4) t = sub_word_ref(t);
      mw[i] = mw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    logic [127:0] v;
    if (r > 14) return '0;
    v = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
`ifdef AES_KS_EQINV_MIXCOL_EN
    if (r >= 1 && r <= 13)
      v = {imc_col_ref(v[127:96]), imc_col_ref(v[95:64]), imc_col_ref(v[63:32]), imc_col_ref(v[31:0])};
`endif
    return v;
  endfunction

  // Monitor: comb instance checked in the issue cycle, registered instance one edge later.
  bit pend1 = 1'b0;
  always @(negedge clk) begin
    if (pend1) begin
      if (q1.size() == 0) begin n_vec++; n_bad++; $display("FAIL rd_reg: read with no expected entry"); end
      else chk("rd_reg", rk_data1, q1.pop_front());
    end
    pend1 = rd_vld;
    if (rd_vld) begin
      if (q0.size() == 0) begin n_vec++; n_bad++; $display("FAIL rd_comb: read with no expected entry"); end
      else chk("rd_comb", rk_data0, q0.pop_front());
    end
  end

  // All driver tasks start and end 1ns after a rising edge.
  task automatic rd(input int idx, input logic [127:0] e);
    rk_idx = 4'(idx);
    rd_vld = 1'b1;
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk); #1;
    rd_vld = 1'b0;
  endtask

  task automatic rd_all();
    for (int r = 0; r < 16; r++) rd(r, exp_rk(r));
  endtask

  task automatic load(input logic [255:0] k);
    key = k;
    key_valid = 1'b1;
    model_expand(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("accept_rk_valid", {rk_valid0, rk_valid1}, 2'b00);
    chk("accept_busy", {busy0, busy1}, 2'b11);
    chk("accept_key_ready", {key_ready0, key_ready1}, 2'b00);
  endtask

  task automatic wait_done(input string nm, input int start);
    int cyc = start;
    while (rk_valid0 !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(nm, cyc, 52);
    chk({nm, "_busy"}, {busy0, busy1}, 2'b00);
    chk({nm, "_rk_valid_reg"}, rk_valid1, 1'b1);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
    return k;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ka;
    rst_n = 1'b0; key_valid = 1'b0; key = '0; rk_idx = 4'd5; rd_vld = 1'b0;
    #12;
    chk("reset_rk_valid", rk_valid0, 1'b0);
    chk("reset_busy", busy0, 1'b0);
    chk("reset_key_ready", key_ready0, 1'b1);
    chk("reset_rk_data", {rk_data0, rk_data1}, 256'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.3 key from IDLE.
    load(C3_KEY);
    wait_done("c3_latency", 0);
    rd(0, C3_RK0);
    rd(14, C3_RK14);
`ifdef AES_KS_EQINV_MIXCOL_EN
    rd(1, exp_rk(1));
`else
    rd(1, C3_RK1);
`endif
    rd_all();

    // FIPS-197 A.3 key loaded from DONE.
    load(A3_KEY);
    wait_done("a3_latency", 0);
    rk_idx = 4'd14; #2;
    chk("a3_w59", rk_data0[31:0], 32'h706c631e);
`ifndef AES_KS_EQINV_MIXCOL_EN
    rk_idx = 4'd2; #1;
    chk("a3_w8", rk_data0[127:96], 32'h9ba35411);
`endif
    @(posedge clk); #1;
    rd_all();

    // Reload C.3 in DONE.
    load(C3_KEY);
    wait_done("c3_reload_latency", 0);
    rd(15, 128'h0);
    rd(14, C3_RK14);
    rd(13, exp_rk(13));

    // A second key offered during expansion must be ignored.
    ka = rand_key();
    load(ka);
    key = rand_key();
    key_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) chk("hold_key_ready", key_ready0, 1'b0);
    end
    key_valid = 1'b0;
    wait_done("hold_latency", 30);
    rd_all();

    // Reset in the middle of expansion.
    load(rand_key());
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_rk_valid", {rk_valid0, rk_valid1}, 2'b00);
    chk("midrst_busy", {busy0, busy1}, 2'b00);
    chk("midrst_rk_data", {rk_data0, rk_data1}, 256'h0);
    chk("midrst_key_ready", key_ready0, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", {rk_valid0, busy0}, 2'b00);
    rd(3, 128'h0);
    rd(14, 128'h0);
    load(rand_key());
    wait_done("midrst_reload_latency", 0);
    rd_all();

    // Random keys with random read indices.
    for (int n = 0; n < 4; n++) begin
      load(rand_key());
      wait_done("rand_latency", 0);
      for (int j = 0; j < 20; j++) begin
        int r = $urandom_range(0, 15);
        rd(r, exp_rk(r));
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
